conv_window_ctrl: RTL and testbench

Sequencer for the layer's 3x3 line-buffer datapath. Accepts a raster-order pixel stream with valid/ready, drives the shift enable of the per-bit shift-row delay lines, and tracks row and column position. Flags each cycle on which the buffers hold a complete KxK window at the configured stride, and reports that window's output coordinates. Sits between the input pixel source and the convolution MAC array.

---
 rtl/cnn_pkg.sv | 31 +++
 rtl/stride_pos_cnt.sv | 82 ++++++++
 rtl/conv_window_ctrl.sv | 132 +++++++++++++
 tb/tb_conv_window_ctrl.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
// Shared layer constants and controller state type for the 3x3 convolution
// front end. The window controller and the shift-row line buffers both derive
// their geometry from here, so the line-buffer depth and the window position
// logic cannot drift apart.
//
// Contents:
//   win_state_t   - controller states IDLE / FILL / RUN / DONE
//   LAYER_*       - frame size, kernel edge and stride of this layer
//   LINE_DEPTH    - shift-row delay line depth (IMG_W - K)
//   cnt_width()   - counter width for a given extent, never below 1 bit
package cnn_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    RUN  = 2'd2,
    DONE = 2'd3
  } win_state_t;

  localparam int LAYER_IMG_W  = 199;
  localparam int LAYER_IMG_H  = 199;
  localparam int LAYER_K      = 3;
  localparam int LAYER_STRIDE = 1;
  localparam int LINE_DEPTH   = LAYER_IMG_W - LAYER_K;

  // $clog2(1) is 0, which would give a zero-width counter.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/stride_pos_cnt.sv
// One axis (row or column) of the window position tracker. Keeps the pixel
// position along the axis, the stride phase once the position has reached the
// first complete window (K-1), and the output window index along that axis.
//
// The outputs describe the pixel being accepted in the current cycle. When
// 'clear' is high that pixel is position 0, regardless of the stored count, so
// a start-of-frame pixel is both classified and counted in a single cycle.
//
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   clear     - current pixel is position 0 (start of frame)
//   step      - advance past the current pixel
//   idx       - output window index ((pos-(K-1))/STRIDE) of current pixel
//   hit       - current pixel closes a window along this axis
//   last      - current pixel is the final position (N-1)
//   fill_end  - current pixel is the final position before window region
module stride_pos_cnt #(
  parameter int N      = 8,
  parameter int K      = 3,
  parameter int STRIDE = 1,
  parameter int W      = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clear,
  input  logic         step,
  output logic [W-1:0] idx,
  output logic         hit,
  output logic         last,
  output logic         fill_end
);

  localparam int PW = (STRIDE > 1) ? $clog2(STRIDE) : 1;

  logic [W-1:0]  pos_q, pos_b, pos_n, idx_q, idx_n;
  logic [PW-1:0] phase_q, phase_b, phase_n;

  // Below position K-1 the phase and index stay at zero, so the first
  // window along the axis always lands on phase 0 / index 0.
  always_comb begin
    pos_b    = clear ? '0 : pos_q;
    phase_b  = clear ? '0 : phase_q;
    idx      = clear ? '0 : idx_q;
    hit      = (int'(pos_b) >= K - 1) && (phase_b == '0);
    last     = (int'(pos_b) == N - 1);
    fill_end = (int'(pos_b) == K - 2);
    pos_n    = pos_b;
    phase_n  = phase_b;
    idx_n    = idx;
    if (step) begin
      if (last) begin
        pos_n   = '0;
        phase_n = '0;
        idx_n   = '0;
      end else begin
        pos_n = pos_b + W'(1);
        if (int'(pos_b) < K - 1) begin
          phase_n = '0;
          idx_n   = '0;
        end else if (int'(phase_b) == STRIDE - 1) begin
          phase_n = '0;
          idx_n   = idx + W'(1);
        end else begin
          phase_n = phase_b + PW'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pos_q   <= '0;
      phase_q <= '0;
      idx_q   <= '0;
    end else begin
      pos_q   <= pos_n;
      phase_q <= phase_n;
      idx_q   <= idx_n;
    end
  end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequencer for the KxK line-buffer datapath. Accepts a raster-order pixel
// stream, drives the shift enable of the shift-row line buffers, tracks the
// row/column position and announces each complete window at the configured
// stride together with its output coordinates.
//
// Ports:
//   clk, rst    - clock, asynchronous active-high reset
//   in_valid    - source presents a pixel
//   in_first    - pixel is the first of a frame
//   in_ready    - controller accepts a pixel this cycle
//   shift_en    - line buffer shift enable (accepted, frame-bound pixel)
//   out_ready   - MAC array takes the presented window
//   win_valid   - a complete window is presented
//   win_row     - output row index of the presented window
//   win_col     - output column index of the presented window
//   frame_done  - one-cycle pulse after the last pixel of a frame
//   err_sof     - one-cycle pulse after a misplaced / missing start of frame
//   busy        - controller is inside a frame
module conv_window_ctrl
  import cnn_pkg::*;
#(
  parameter int IMG_W  = LAYER_IMG_W,
  parameter int IMG_H  = LAYER_IMG_H,
  parameter int K      = LAYER_K,
  parameter int STRIDE = LAYER_STRIDE,
  parameter int CW     = cnt_width(IMG_W),
  parameter int RW     = cnt_width(IMG_H)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  input  logic          in_first,
  output logic          in_ready,
  output logic          shift_en,
  input  logic          out_ready,
  output logic          win_valid,
  output logic [RW-1:0] win_row,
  output logic [CW-1:0] win_col,
  output logic          frame_done,
  output logic          err_sof,
  output logic          busy
);

  win_state_t    state, state_n;
  logic          accept, restart, row_step, win_hit, err_n;
  logic          col_hit, col_last, col_fill_end_unused;
  logic          row_hit, row_last, row_fill_end;
  logic [CW-1:0] col_idx;
  logic [RW-1:0] row_idx;

  // A held window blocks input so the buffers never shift under it.
  assign in_ready   = (state != DONE) && (out_ready || !win_valid);
  assign accept     = in_valid && in_ready;
  assign shift_en   = accept && !(state == IDLE && !in_first);
  assign restart    = accept && in_first;
  assign row_step   = shift_en && col_last;
  assign win_hit    = shift_en && row_hit && col_hit;
  assign busy       = (state != IDLE);
  assign frame_done = (state == DONE);

  stride_pos_cnt #(
    .N(IMG_W), .K(K), .STRIDE(STRIDE), .W(CW)
  ) u_col (
    .clk(clk), .rst(rst), .clear(restart), .step(shift_en),
    .idx(col_idx), .hit(col_hit), .last(col_last),
    .fill_end(col_fill_end_unused)
  );

  stride_pos_cnt #(
    .N(IMG_H), .K(K), .STRIDE(STRIDE), .W(RW)
  ) u_row (
    .clk(clk), .rst(rst), .clear(restart), .step(row_step),
    .idx(row_idx), .hit(row_hit), .last(row_last),
    .fill_end(row_fill_end)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  // A start-of-frame pixel always restarts the frame, even when it arrives
  // mid-frame on the final position, so it can never also end the frame.
  always_comb begin
    state_n = state;
    err_n   = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          if (!in_first)                 err_n   = 1'b1;
          else if (row_last && col_last) state_n = DONE;
          else                           state_n = (K == 1) ? RUN : FILL;
        end
      end
      FILL, RUN: begin
        if (accept) begin
          if (in_first) begin
            err_n   = 1'b1;
            state_n = (K == 1) ? RUN : FILL;
          end else if (row_last && col_last) begin
            state_n = DONE;
          end else if (state == FILL && row_step && row_fill_end) begin
            state_n = RUN;
          end
        end
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // win_hit implies accept, which implies the previous window was taken,
  // so a new window never overwrites one still waiting for out_ready.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      win_valid <= 1'b0;
      win_row   <= '0;
      win_col   <= '0;
      err_sof   <= 1'b0;
    end else begin
      err_sof <= err_n;
      if (win_hit) begin
        win_valid <= 1'b1;
        win_row   <= row_idx;
        win_col   <= col_idx;
      end else if (out_ready) begin
        win_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Self-checking bench for conv_window_ctrl. Two instances: a 5x4 frame at
// stride 1 and a 7x7 frame at stride 2, both with a 3x3 kernel. A frame-level
// reference model (pixel index -> row/col by division, window test by modulo)
// predicts every output each cycle.
module tb_conv_window_ctrl;

  localparam int K = 3;

  logic       clk = 1'b0;
  logic [1:0] rst, in_valid, in_first, out_ready;
  logic [1:0] in_ready, shift_en, win_valid, frame_done, err_sof, busy;
  logic [1:0] win_row0;
  logic [2:0] win_col0, win_row1, win_col1;

  int asserts = 0;
  int fails   = 0;

  bit m_active[2], m_done[2], m_wv[2], m_err[2];
  int m_pos[2], m_wr[2], m_wc[2], m_wins[2], m_shifts[2];

  always #5 clk = ~clk;

  conv_window_ctrl #(.IMG_W(5), .IMG_H(4), .K(3), .STRIDE(1)) dut0 (
    .clk(clk), .rst(rst[0]), .in_valid(in_valid[0]), .in_first(in_first[0]),
    .in_ready(in_ready[0]), .shift_en(shift_en[0]), .out_ready(out_ready[0]),
    .win_valid(win_valid[0]), .win_row(win_row0), .win_col(win_col0),
    .frame_done(frame_done[0]), .err_sof(err_sof[0]), .busy(busy[0])
  );

  conv_window_ctrl #(.IMG_W(7), .IMG_H(7), .K(3), .STRIDE(2)) dut1 (
    .clk(clk), .rst(rst[1]), .in_valid(in_valid[1]), .in_first(in_first[1]),
    .in_ready(in_ready[1]), .shift_en(shift_en[1]), .out_ready(out_ready[1]),
    .win_valid(win_valid[1]), .win_row(win_row1), .win_col(win_col1),
    .frame_done(frame_done[1]), .err_sof(err_sof[1]), .busy(busy[1])
  );

  function automatic int w_of(input int u); return (u == 0) ? 5 : 7; endfunction
  function automatic int h_of(input int u); return (u == 0) ? 4 : 7; endfunction
  function automatic int s_of(input int u); return (u == 0) ? 1 : 2; endfunction

  task automatic checkOutput(input string tag, input int obs, input int exp);
    asserts++;
    assert (obs === exp) else begin
      fails++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic resetModel(input int u);
    m_active[u] = 0; m_done[u] = 0; m_wv[u] = 0; m_err[u] = 0;
    m_pos[u] = 0; m_wr[u] = 0; m_wc[u] = 0;
  endtask

  // One clock cycle on instance u: drive, check combinational outputs,
  // advance the model at the edge, check registered outputs on the next
  // falling edge.
  task automatic applyStimulus(input int u, input bit v, input bit f,
                               input bit ordy, output bit acc);
    bit exp_rdy, exp_sh, win;
    int p, r, c, s, w, h;
    in_valid[u]  = v;
    in_first[u]  = f;
    out_ready[u] = ordy;
    #1;
    exp_rdy = !m_done[u] && (ordy || !m_wv[u]);
    acc     = v && exp_rdy;
    exp_sh  = acc && (m_active[u] || f);
    checkOutput("in_ready", int'(in_ready[u]), int'(exp_rdy));
    checkOutput("shift_en", int'(shift_en[u]), int'(exp_sh));
    @(posedge clk);
    s = s_of(u); w = w_of(u); h = h_of(u);
    m_err[u] = 0;
    win = 0;
    if (m_done[u]) begin
      m_done[u] = 0;
    end else if (acc) begin
      if (f == m_active[u]) m_err[u] = 1;
      if (exp_sh) begin
        m_shifts[u]++;
        p = f ? 0 : m_pos[u];
        r = p / w;
        c = p % w;
        if (r >= K-1 && c >= K-1 && (r-(K-1)) % s == 0 && (c-(K-1)) % s == 0) begin
          win     = 1;
          m_wr[u] = (r - (K-1)) / s;
          m_wc[u] = (c - (K-1)) / s;
          m_wins[u]++;
        end
        if (p == w*h - 1) begin
          m_done[u] = 1; m_active[u] = 0; m_pos[u] = 0;
        end else begin
          m_active[u] = 1; m_pos[u] = p + 1;
        end
      end
    end
    if (win)       m_wv[u] = 1;
    else if (ordy) m_wv[u] = 0;
    @(negedge clk);
    checkOutput("win_valid", int'(win_valid[u]), int'(m_wv[u]));
    checkOutput("win_row", (u == 0) ? int'(win_row0) : int'(win_row1), m_wr[u]);
    checkOutput("win_col", (u == 0) ? int'(win_col0) : int'(win_col1), m_wc[u]);
    checkOutput("frame_done", int'(frame_done[u]), int'(m_done[u]));
    checkOutput("err_sof", int'(err_sof[u]), int'(m_err[u]));
    checkOutput("busy", int'(busy[u]), int'(m_active[u] || m_done[u]));
  endtask

  // Pushes npix pixels with pv% valid and pr% out_ready probability. The
  // first pixel carries in_first when sof_first is set; pixel sof_at (if
  // non-negative) carries it too.
  task automatic sendPixels(input int u, input int npix, input bit sof_first,
                            input int sof_at, input int pv, input int pr);
    int sent, cyc;
    bit acc, v, f, o;
    sent = 0;
    cyc  = 0;
    while (sent < npix && cyc < 3000) begin
      v = int'($urandom_range(99)) < pv;
      o = int'($urandom_range(99)) < pr;
      f = (sof_first && sent == 0) || (sent == sof_at);
      applyStimulus(u, v, f, o, acc);
      if (acc) sent++;
      cyc++;
    end
    checkOutput("pixel_budget", sent, npix);
  endtask

  task automatic idleCycles(input int u, input int n);
    bit acc;
    for (int i = 0; i < n; i++) applyStimulus(u, 1'b0, 1'b0, 1'b1, acc);
  endtask

  initial begin
    int  w0, s0;
    bit  acc;
    rst       = 2'b11;
    in_valid  = 2'b00;
    in_first  = 2'b00;
    out_ready = 2'b11;
    resetModel(0);
    resetModel(1);
    m_wins[0] = 0; m_wins[1] = 0; m_shifts[0] = 0; m_shifts[1] = 0;
    repeat (2) @(negedge clk);
    for (int u = 0; u < 2; u++) begin
      checkOutput("rst_win_valid", int'(win_valid[u]), 0);
      checkOutput("rst_busy", int'(busy[u]), 0);
      checkOutput("rst_frame_done", int'(frame_done[u]), 0);
      checkOutput("rst_err_sof", int'(err_sof[u]), 0);
      checkOutput("rst_in_ready", int'(in_ready[u]), 1);
    end
    rst = 2'b00;

    $display("[TB] 5x4 stride 1, continuous stream");
    w0 = m_wins[0]; s0 = m_shifts[0];
    sendPixels(0, 20, 1'b1, -1, 100, 100);
    idleCycles(0, 3);
    checkOutput("s1_windows", m_wins[0] - w0, 6);
    checkOutput("s1_shifts", m_shifts[0] - s0, 20);

    $display("[TB] 7x7 stride 2, continuous stream");
    w0 = m_wins[1];
    sendPixels(1, 49, 1'b1, -1, 100, 100);
    idleCycles(1, 3);
    checkOutput("s2_windows", m_wins[1] - w0, 9);

    $display("[TB] output back-pressure hold");
    w0 = m_wins[0];
    sendPixels(0, 13, 1'b1, -1, 100, 100);
    checkOutput("hold_first_valid", int'(win_valid[0]), 1);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b1, 1'b0, 1'b0, acc);
    checkOutput("hold_still_valid", int'(win_valid[0]), 1);
    sendPixels(0, 7, 1'b0, -1, 100, 100);
    idleCycles(0, 3);
    checkOutput("hold_windows", m_wins[0] - w0, 6);

    $display("[TB] non-sof pixel while idle");
    applyStimulus(0, 1'b1, 1'b0, 1'b1, acc);
    checkOutput("idle_err_pulse", int'(err_sof[0]), 1);
    checkOutput("idle_stays_idle", int'(busy[0]), 0);
    w0 = m_wins[0];
    sendPixels(0, 20, 1'b1, -1, 100, 100);
    idleCycles(0, 3);
    checkOutput("after_err_windows", m_wins[0] - w0, 6);

    $display("[TB] sof injected at (2,3)");
    // One window at (2,2) before the restart, then a full frame of six.
    w0 = m_wins[0];
    sendPixels(0, 33, 1'b1, 13, 100, 100);
    idleCycles(0, 3);
    checkOutput("midsof_windows", m_wins[0] - w0, 7);

    $display("[TB] random valid / ready");
    for (int n = 0; n < 3; n++) begin
      w0 = m_wins[0]; s0 = m_shifts[0];
      sendPixels(0, 20, 1'b1, -1, 70, 60);
      idleCycles(0, 4);
      checkOutput("rnd0_windows", m_wins[0] - w0, 6);
      checkOutput("rnd0_shifts", m_shifts[0] - s0, 20);
      w0 = m_wins[1];
      sendPixels(1, 49, 1'b1, -1, 75, 55);
      idleCycles(1, 4);
      checkOutput("rnd1_windows", m_wins[1] - w0, 9);
    end

    $display("[TB] asynchronous reset mid-run");
    sendPixels(0, 15, 1'b1, -1, 100, 100);
    #2 rst[0] = 1'b1;
    #1;
    checkOutput("arst_win_valid", int'(win_valid[0]), 0);
    checkOutput("arst_busy", int'(busy[0]), 0);
    checkOutput("arst_frame_done", int'(frame_done[0]), 0);
    resetModel(0);
    in_valid[0] = 1'b0;
    @(negedge clk);
    rst[0] = 1'b0;
    w0 = m_wins[0];
    sendPixels(0, 20, 1'b1, -1, 100, 100);
    idleCycles(0, 3);
    checkOutput("arst_windows", m_wins[0] - w0, 6);

    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule
